muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative, multi-cycle RV32M/RV64M multiply/divide unit with valid/ready handshakes on input and output.
- Parametrised successor to the single-cycle ALU multiply path; adds DIV/DIVU/REM/REMU.
- Sits beside the ALU in the execute stage; the pipeline stalls on in_ready/out_valid.
- Trades latency for area with a configurable bits-per-cycle iteration.

Parameters:
WIDTH, 32, operand/result width (32 or 64)
BITS_PER_CYCLE, 1, bits retired per iteration; must divide WIDTH (1, 2, 4)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request
op  in  3  muldiv_op_e (funct3 encoding)
operand_a  in  WIDTH  rs1 value
operand_b  in  WIDTH  rs2 value
kill  in  1  synchronous abort of the in-flight op (pipeline flush)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  selected result
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, out_valid=0, result=0, busy=0, counter=0. in_ready=1 once rst_n is high. Reset asserted mid-op drops to IDLE at once, with no output.
- N = WIDTH/BITS_PER_CYCLE.
- States:
  - IDLE -> CALC on accept (in_valid && in_ready). Latch op and operand magnitudes; record result sign; counter=N-1.
  - IDLE -> DONE on a fast-path accept.
  - CALC -> DONE when counter==0 at the edge; otherwise counter--.
  - DONE -> IDLE on out_valid && out_ready.
- in_ready = (state==IDLE) && !kill. There is no accept in the same cycle as a DONE->IDLE handoff.
- Latency, with accept edge = E0:
  - Normal: out_valid high from edge E_N, so N cycles.
  - Fast path: out_valid high from E0, so it is visible in the cycle after accept.
- Fast paths (division only):
  - Divide by zero: quotient = all ones, remainder = operand_a.
  - Signed overflow (DIV/REM of most-negative by -1): quotient = most-negative, remainder = 0.
- Multiply:
  - Unsigned shift-add over magnitudes into a 2*WIDTH accumulator.
  - Signed operand a applies to MUL/MULH/MULHSU; signed operand b applies to MUL/MULH only.
  - Product is negated if sign_a XOR sign_b.
  - MUL returns the low WIDTH bits; MULH/MULHSU/MULHU return the high WIDTH bits.
- Divide:
  - Restoring division over magnitudes.
  - Quotient is negated if the signs differ (signed ops).
  - Remainder takes the sign of the dividend.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Sign correction is applied on the final CALC step; result is registered on entry to DONE.
- In DONE, result and out_valid hold stable while out_ready=0 (no glitch, no change).
- kill:
  - Any state -> IDLE at the next edge; out_valid=0 next cycle; result is not updated.
  - kill overrides a simultaneous in_valid (no accept) and a simultaneous out_ready.
- op, operand_a and operand_b are ignored except at accept. Inputs may change during CALC.

Decomposition:
- muldiv_pkg holds:
  - typedef enum logic [2:0] muldiv_op_e: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
  - typedef enum state_e: IDLE, CALC, DONE.
  - Helper functions is_div(op), a_signed(op), b_signed(op).
- Sub-module muldiv_step: combinational single-bit step (shift-add for multiply / trial-subtract for divide). Instantiated BITS_PER_CYCLE times in a chain inside muldiv_unit.

Test Plan:
- MUL then MULH with a=0xFFFFFFFE, b=3, BITS_PER_CYCLE=1:
  - MUL -> 0xFFFFFFFA; MULH -> 0xFFFFFFFF.
  - out_valid rises exactly 32 edges after accept; in_ready=0 throughout.
- MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- MULHU with the same operands -> 0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD.
- REM with the same operands -> 0xFFFFFFFF.
- DIVU a=5, b=0 -> 0xFFFFFFFF.
- REMU a=5, b=0 -> 5; out_valid visible the cycle after accept.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0; both take the fast path.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result/out_valid stable and in_ready=0. Then out_ready=1 -> IDLE next edge.
- kill at CALC counter=10 -> IDLE next edge, no out_valid. A following MUL 6*7 -> 42 is correct.
- rst_n low mid-CALC -> immediate IDLE with all outputs at reset values.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and op-decoding helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_div(input muldiv_op_e op);
        return op[2];
    endfunction

    // Signed divides are DIV/REM (funct3[0] clear); MULHU is the only fully unsigned multiply.
    function automatic logic a_signed(input muldiv_op_e op);
        return op[2] ? !op[0] : (op != MULHU);
    endfunction

    function automatic logic b_signed(input muldiv_op_e op);
        return op[2] ? !op[0] : (op == MUL || op == MULH);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_if #(parameter int WIDTH = 32);
    import muldiv_pkg::*;

    // A transfer happens on an edge where valid && ready; valid never waits on ready,
    // and kill suppresses the input transfer in the same cycle.
    logic             in_valid;
    logic             in_ready;
    muldiv_op_e       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             kill;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             busy;
    state_e           dbg_state;

    modport master (
        output in_valid, op, operand_a, operand_b, kill, out_ready,
        input  in_ready, out_valid, result, busy, dbg_state
    );

    modport slave (
        input  in_valid, op, operand_a, operand_b, kill, out_ready,
        output in_ready, out_valid, result, busy, dbg_state
    );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring trial-subtract divide on {hi, lo}.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
        shifted = {hi, lo[WIDTH-1]};
        fits    = (shifted >= {1'b0, operand});
        // The partial remainder after a successful subtract is below the divisor, so W bits suffice.
        diff    = shifted[WIDTH-1:0] - operand;

        if (is_div) begin
            hi_next = fits ? diff : shifted[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], fits};
        end else begin
            hi_next = sum[WIDTH:1];
            lo_next = {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit retiring BITS_PER_CYCLE bits per CALC cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state;
    logic [CW-1:0]    counter;
    muldiv_op_e       op_q;
    logic [WIDTH-1:0] hi_q, lo_q, b_q, result_q;
    logic             sa_q, sb_q;

    logic             accept, sa, sb, div_zero, div_ovf;
    logic [WIDTH-1:0] mag_a, mag_b, fast_result, final_result, quot, rem;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0] hi_c [BITS_PER_CYCLE+1];
    logic [WIDTH-1:0] lo_c [BITS_PER_CYCLE+1];

    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.in_ready  = (state == S_IDLE) && !bus.kill;
    assign bus.out_valid = (state == S_DONE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.result    = result_q;
    assign bus.dbg_state = state_e'(state);

    always_comb begin
        sa       = a_signed(bus.op) && bus.operand_a[WIDTH-1];
        sb       = b_signed(bus.op) && bus.operand_b[WIDTH-1];
        mag_a    = sa ? -bus.operand_a : bus.operand_a;
        mag_b    = sb ? -bus.operand_b : bus.operand_b;
        div_zero = is_div(bus.op) && (bus.operand_b == '0);
        div_ovf  = is_div(bus.op) && !bus.op[0] && (bus.operand_a == MOST_NEG) &&
                   (bus.operand_b == '1);
        // op[1] selects remainder among the divide encodings.
        if (div_zero) fast_result = bus.op[1] ? bus.operand_a : '1;
        else          fast_result = bus.op[1] ? '0 : MOST_NEG;
    end

    assign hi_c[0] = hi_q;
    assign lo_c[0] = lo_q;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        muldiv_step #(.WIDTH(WIDTH)) u_step (
            .is_div  (is_div(op_q)),
            .hi      (hi_c[g]),
            .lo      (lo_c[g]),
            .operand (b_q),
            .hi_next (hi_c[g+1]),
            .lo_next (lo_c[g+1])
        );
    end

    always_comb begin
        prod   = {hi_c[BITS_PER_CYCLE], lo_c[BITS_PER_CYCLE]};
        prod_s = (sa_q ^ sb_q) ? -prod : prod;
        quot   = (sa_q ^ sb_q) ? -lo_c[BITS_PER_CYCLE] : lo_c[BITS_PER_CYCLE];
        rem    = sa_q ? -hi_c[BITS_PER_CYCLE] : hi_c[BITS_PER_CYCLE];
        case (op_q)
            MUL:               final_result = prod_s[WIDTH-1:0];
            MULH, MULHSU, MULHU: final_result = prod_s[2*WIDTH-1:WIDTH];
            DIV, DIVU:         final_result = quot;
            default:           final_result = rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            counter  <= '0;
            op_q     <= MUL;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            result_q <= '0;
        end else if (bus.kill) begin
            state   <= S_IDLE;
            counter <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    op_q <= bus.op;
                    hi_q <= '0;
                    lo_q <= mag_a;
                    b_q  <= mag_b;
                    sa_q <= sa;
                    sb_q <= sb;
                    if (div_zero || div_ovf) begin
                        result_q <= fast_result;
                        state    <= S_DONE;
                    end else begin
                        counter <= CW'(N - 1);
                        state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    hi_q <= hi_c[BITS_PER_CYCLE];
                    lo_q <= lo_c[BITS_PER_CYCLE];
                    if (counter == '0) begin
                        result_q <= final_result;
                        state    <= S_DONE;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                S_DONE: if (bus.out_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomised checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [W-1:0] exp_q[$];

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        longint pa, pb;
        logic [63:0] r;
        int sa, sb;
        logic ovf;
        pa  = {{32{a[31]}}, a};
        pb  = {{32{b[31]}}, b};
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = '0;
        case (op)
            3'b000: begin r = pa * pb; return r[31:0]; end
            3'b001: begin r = pa * pb; return r[63:32]; end
            3'b010: begin r = pa * longint'({32'b0, b}); return r[63:32]; end
            3'b011: begin r = {32'b0, a} * {32'b0, b}; return r[63:32]; end
            3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : W'(sa / sb);
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: return (b == 0) ? a : ovf ? 32'h0 : W'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
        if (op[2] && b == 0) return 0;
        if (op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return W;
    endfunction

    // Presents one request at a negedge; returns just after the accept edge.
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        check("in_ready_before_send", 64'(bus.in_ready), 64'd1);
        bus.in_valid  = 1'b1;
        bus.op        = muldiv_op_e'(op);
        bus.operand_a = a;
        bus.operand_b = b;
        exp_q.push_back(ref_model(op, a, b));
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.op        = muldiv_op_e'($urandom_range(0, 7));
        bus.operand_a = $urandom;
        bus.operand_b = $urandom;
    endtask

    task automatic collect(input string tag, input int exp_lat, input int hold);
        int k = 0;
        logic ready_low = 1'b1;
        logic stable = 1'b1;
        logic [W-1:0] held;
        logic [W-1:0] expv;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1 || k > 200) break;
            if (bus.in_ready !== 1'b0) ready_low = 1'b0;
            k++;
        end
        check({tag, "_latency"}, 64'(k), 64'(exp_lat));
        if (exp_lat > 0) check({tag, "_in_ready_low"}, 64'(ready_low), 64'd1);
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check({tag, "_result"}, 64'(bus.result), 64'(expv));
        held = bus.result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.result !== held || bus.in_ready !== 1'b0)
                stable = 1'b0;
        end
        if (hold > 0) check({tag, "_hold_stable"}, 64'(stable), 64'd1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_drained"}, {62'd0, bus.out_valid, bus.busy}, 64'd0);
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int hold);
        send(op, a, b);
        collect(tag, ref_latency(op, a, b), hold);
    endtask

    initial begin
        logic seen_valid;
        bus.in_valid  = 1'b0;
        bus.op        = MUL;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.kill      = 1'b0;
        bus.out_ready = 1'b0;

        #12;
        check("reset_outputs", {61'd0, bus.out_valid, bus.busy, bus.dbg_state == IDLE}, 64'd1);
        check("reset_result", 64'(bus.result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", 64'(bus.in_ready), 64'd1);

        run("mul",    3'b000, 32'hFFFF_FFFE, 32'd3, 0);
        check("mul_const", 64'(ref_model(3'b000, 32'hFFFF_FFFE, 32'd3)), 64'hFFFF_FFFA);
        run("mulh",   3'b001, 32'hFFFF_FFFE, 32'd3, 0);
        run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run("div",    3'b100, 32'hFFFF_FFF9, 32'd2, 0);
        run("rem",    3'b110, 32'hFFFF_FFF9, 32'd2, 0);
        run("divu_z", 3'b101, 32'd5, 32'd0, 0);
        run("remu_z", 3'b111, 32'd5, 32'd0, 0);
        run("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run("div_z_signed", 3'b110, 32'h8000_0001, 32'd0, 0);
        run("backpressure", 3'b101, 32'd1000, 32'd7, 5);

        // Kill while counter is 10: after the accept edge it sits at 31 and drops by one per edge.
        send(3'b000, 32'd123, 32'd456);
        repeat (21) @(posedge clk);
        @(negedge clk);
        check("kill_in_calc", 64'(bus.dbg_state), 64'(CALC));
        bus.kill      = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.kill      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        check("kill_idle", {61'd0, bus.out_valid, bus.busy, bus.in_ready}, 64'd1);
        seen_valid = 1'b0;
        repeat (40) begin
          @(negedge clk);
          if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen_valid = 1'b1;
        end
        check("kill_no_output", 64'(seen_valid), 64'd0);
        run("mul_after_kill", 3'b000, 32'd6, 32'd7, 0);
        check("mul_6x7_const", 64'(ref_model(3'b000, 32'd6, 32'd7)), 64'd42);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] op;
            logic [W-1:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (i % 3 == 0) ? W'($urandom_range(1, 15)) : $urandom;
            if (i % 2 == 1) b = -b;
            run("random", op, a, b, $urandom_range(0, 2));
        end

        // Asynchronous reset part-way through CALC.
        send(3'b101, 32'd99, 32'd4);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_calc", {61'd0, bus.out_valid, bus.busy, bus.dbg_state == IDLE}, 64'd1);
        check("rst_mid_result", 64'(bus.result), 64'd0);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        run("after_reset", 3'b001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
